// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants for the data-memory controller.
//   - timer register byte offsets relative to MMIO_BASE
//   - CTRL register bit positions
//   - core size-mask encodings (unshifted, as presented on wmask_i)
package dmem_pkg;

    localparam logic [3:0] TMR_MTIME    = 4'h0;
    localparam logic [3:0] TMR_MTIMECMP = 4'h4;
    localparam logic [3:0] TMR_CTRL     = 4'h8;
    localparam logic [3:0] TMR_RSVD     = 4'hC;

    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned CTRL_PEND = 1;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

endpackage

// File: rtl/dmem_timer.sv
// dmem_timer: memory-mapped timer (MTIME, MTIMECMP, CTRL) with compare interrupt.
// Ports:
//   clk_i, reset_i  clock, asynchronous active-low reset
//   we_i            word write strobe (already qualified: aligned full-word MMIO store)
//   off_i           register byte offset within the 16-byte window
//   wdata_i         write data
//   rdata_o         combinational read data of the addressed register (pre-increment value)
//   irq_o           CTRL.PEND
module dmem_timer
    import dmem_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        we_i,
    input  logic [3:0]  off_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);

    logic [31:0] mtime_q, mtime_d;
    logic [31:0] cmp_q, cmp_d;
    logic        en_q, en_d;
    logic        pend_q, pend_d;

    always_comb begin
        mtime_d = mtime_q;
        cmp_d   = cmp_q;
        en_d    = en_q;
        pend_d  = pend_q;

        // Software write to MTIME wins over the increment.
        if (we_i && off_i == TMR_MTIME) begin
            mtime_d = wdata_i;
        end else if (en_q) begin
            mtime_d = mtime_q + 32'd1;
        end

        if (we_i && off_i == TMR_MTIMECMP) begin
            cmp_d = wdata_i;
        end

        if (we_i && off_i == TMR_CTRL) begin
            en_d = wdata_i[CTRL_EN];
            if (wdata_i[CTRL_PEND]) begin
                pend_d = 1'b0;
            end
        end

        // Compare uses the registered MTIME, so a freshly written value matches a cycle later.
        // Set is applied last so it beats a same-cycle W1C.
        if (en_q && mtime_q == cmp_q) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            mtime_q <= 32'h0;
            cmp_q   <= 32'hFFFF_FFFF;
            en_q    <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            en_q    <= en_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        rdata_o = 32'h0;
        case (off_i)
            TMR_MTIME:    rdata_o = mtime_q;
            TMR_MTIMECMP: rdata_o = cmp_q;
            TMR_CTRL:     rdata_o = {30'h0, pend_q, en_q};
            TMR_RSVD:     rdata_o = 32'h0;
            default:      rdata_o = 32'h0;
        endcase
    end

    assign irq_o = pend_q;

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller behind the core's EX-stage data port.
// Aligns byte/half/word stores into a word-wide synchronous SRAM and returns right-justified
// load data one cycle after the request. Misaligned accesses are suppressed (store) or read
// as zero (load) and flagged on misalign_o alongside the response.
// Build option: define DMEM_MMIO_TIMER_EN to decode a timer at MMIO_BASE..MMIO_BASE+15;
// otherwise the whole space is SRAM and irq_o is tied low.
// Ports:
//   clk_i, reset_i  clock, asynchronous active-low reset
//   wen_i           active-low store enable (1 = load / no-op)
//   wmask_i         unshifted size mask (0001 byte, 0011 half, 1111 word)
//   addr_i          byte address
//   wdata_i         right-justified store data
//   rdata_o         right-justified load data, valid the cycle after the request
//   misalign_o      misaligned-access flag, same timing as rdata_o
//   irq_o           timer interrupt pending
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 512,
    parameter logic [10:0] MMIO_BASE   = 11'h7F0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        wen_i,
    input  logic [3:0]  wmask_i,
    input  logic [10:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        irq_o
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [1:0]    off;
    logic [AW-1:0] idx;
    logic          mmio;
    logic          misalign;
    logic          sram_we;
    logic [3:0]    lane_mask;
    logic [31:0]   lane_data;

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [31:0]   word_q;
    logic [1:0]    off_q;
    logic          mis_q;

    assign off = addr_i[1:0];
    assign idx = addr_i[AW+1:2];

    always_comb begin
        lane_mask = wmask_i << off;
        lane_data = wdata_i << {off, 3'b000};
        misalign  = ((wmask_i == MASK_H) && (off == 2'd3))
                 || ((wmask_i == MASK_W) && (off != 2'd0))
                 || (mmio && (wmask_i != MASK_W));
        sram_we   = !wen_i && !misalign && !mmio;
    end

`ifdef DMEM_MMIO_TIMER_EN
    logic [3:0]  tmr_off;
    logic [31:0] tmr_rdata;
    logic [31:0] tmr_q;
    logic        tmr_we;
    logic        mmio_q;

    assign mmio    = (addr_i >= MMIO_BASE) && ({1'b0, addr_i} < ({1'b0, MMIO_BASE} + 12'd16));
    assign tmr_off = addr_i[3:0] - MMIO_BASE[3:0];
    assign tmr_we  = !wen_i && mmio && !misalign;

    dmem_timer u_timer (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .we_i    (tmr_we),
        .off_i   (tmr_off),
        .wdata_i (wdata_i),
        .rdata_o (tmr_rdata),
        .irq_o   (irq_o)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            tmr_q  <= 32'h0;
            mmio_q <= 1'b0;
        end else begin
            tmr_q  <= tmr_rdata;
            mmio_q <= mmio;
        end
    end
`else
    logic unused_mmio_base;

    assign mmio             = 1'b0;
    assign irq_o            = 1'b0;
    assign unused_mmio_base = ^MMIO_BASE;
`endif

    // SRAM array: byte-lane writes, contents not reset.
    always_ff @(posedge clk_i) begin
        if (sram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_mask[b]) begin
                    mem_q[idx][8*b +: 8] <= lane_data[8*b +: 8];
                end
            end
        end
    end

    // Read port samples the pre-write array contents, giving read-first behaviour.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            word_q <= 32'h0;
            off_q  <= 2'd0;
            mis_q  <= 1'b0;
        end else begin
            word_q <= mem_q[idx];
            off_q  <= off;
            mis_q  <= misalign;
        end
    end

    always_comb begin
        rdata_o = word_q >> {off_q, 3'b000};
`ifdef DMEM_MMIO_TIMER_EN
        if (mmio_q) begin
            rdata_o = tmr_q;
        end
`endif
        if (mis_q) begin
            rdata_o = 32'h0;
        end
    end

    assign misalign_o = mis_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: randomized and directed checks of dmem_ctrl against a byte-array memory model.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        wen_i;
    logic [3:0]  wmask_i;
    logic [10:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        misalign_o;
    logic        irq_o;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [7:0]  mem_m [2048];

`ifdef DMEM_MMIO_TIMER_EN
    localparam int unsigned SramTop = 'h7F0;
`else
    localparam int unsigned SramTop = 'h800;
`endif
    localparam logic [10:0] Base = 11'h7F0;

    always #5 clk_i = ~clk_i;

    dmem_ctrl dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .wen_i      (wen_i),
        .wmask_i    (wmask_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata_o),
        .misalign_o (misalign_o),
        .irq_o      (irq_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // One request cycle; the model answers with the word as it stood before this request's store.
    task automatic req(input logic wen, input logic [3:0] mask, input logic [10:0] addr,
                       input logic [31:0] wd, input bit chk, output logic [31:0] got);
        int unsigned off, sz, base;
        logic [31:0] word, exp;
        bit          mis;
        off  = int'(addr[1:0]);
        base = int'(addr) - off;
        sz   = (mask == MASK_W) ? 4 : (mask == MASK_H) ? 2 : 1;
        mis  = (off + sz) > 4;
        word = {mem_m[base+3], mem_m[base+2], mem_m[base+1], mem_m[base]};
        exp  = mis ? 32'h0 : (word >> (8 * off));
        if (!wen && !mis && int'(addr) < SramTop) begin
            for (int i = 0; i < int'(sz); i++) mem_m[int'(addr) + i] = wd[8*i +: 8];
        end
        @(negedge clk_i);
        wen_i   = wen;
        wmask_i = mask;
        addr_i  = addr;
        wdata_i = wd;
        @(posedge clk_i);
        #1;
        got   = rdata_o;
        wen_i = 1'b1;
        if (chk) begin
            check($sformatf("rdata@%03h", addr), rdata_o, exp);
            check($sformatf("misalign@%03h", addr), {31'h0, misalign_o}, {31'h0, mis});
        end
    endtask

    logic [31:0] v;
    logic [3:0]  m;
    bit          seen;

    initial begin
        reset_i = 1'b0;
        wen_i   = 1'b1;
        wmask_i = MASK_W;
        addr_i  = '0;
        wdata_i = '0;
        #1;
        check("reset_rdata", rdata_o, 32'h0);
        check("reset_misalign", {31'h0, misalign_o}, 32'h0);
        check("reset_irq", {31'h0, irq_o}, 32'h0);
        @(negedge clk_i);
        reset_i = 1'b1;

`ifdef DMEM_MMIO_TIMER_EN
        req(1'b1, MASK_W, Base + 11'(TMR_MTIMECMP), 32'h0, 1'b0, v);
        check("tmr_cmp_reset", v, 32'hFFFF_FFFF);
        req(1'b1, MASK_W, Base + 11'(TMR_MTIME), 32'h0, 1'b0, v);
        check("tmr_mtime_reset", v, 32'h0);
`endif

        // Fill the SRAM so every model byte is known.
        for (int a = 0; a < int'(SramTop); a += 4) req(1'b0, MASK_W, 11'(a), $urandom, 1'b0, v);

        // Byte store into a zeroed word.
        req(1'b0, MASK_W, 11'h010, 32'h0, 1'b1, v);
        req(1'b0, MASK_B, 11'h013, 32'hFFFF_FFAB, 1'b1, v);
        req(1'b1, MASK_W, 11'h010, 32'h0, 1'b1, v);
        check("byte_word_view", v, 32'hAB00_0000);
        req(1'b1, MASK_B, 11'h013, 32'h0, 1'b1, v);
        check("byte_load", v, 32'h0000_00AB);

        // Half store, other bytes preserved.
        req(1'b0, MASK_W, 11'h020, 32'h1122_3344, 1'b1, v);
        req(1'b0, MASK_H, 11'h022, 32'h0000_1234, 1'b1, v);
        req(1'b1, MASK_H, 11'h022, 32'h0, 1'b1, v);
        check("half_load", v, 32'h0000_1234);
        req(1'b1, MASK_W, 11'h020, 32'h0, 1'b1, v);
        check("half_word_view", v, 32'h1234_3344);

        // Misaligned store suppressed, misaligned load reads zero.
        req(1'b0, MASK_W, 11'h030, 32'hCAFE_F00D, 1'b1, v);
        req(1'b0, MASK_W, 11'h031, 32'hDEAD_BEEF, 1'b1, v);
        check("mis_store_flag", {31'h0, misalign_o}, 32'h1);
        req(1'b1, MASK_W, 11'h030, 32'h0, 1'b1, v);
        check("mis_store_dropped", v, 32'hCAFE_F00D);
        req(1'b1, MASK_H, 11'h033, 32'h0, 1'b1, v);
        check("mis_load_zero", v, 32'h0);
        check("mis_load_flag", {31'h0, misalign_o}, 32'h1);

        // Read-during-write returns old data.
        req(1'b0, MASK_W, 11'h040, 32'h0, 1'b1, v);
        req(1'b0, MASK_B, 11'h040, 32'h0000_0055, 1'b1, v);
        check("rdw_old", v, 32'h0);
        req(1'b1, MASK_W, 11'h040, 32'h0, 1'b1, v);
        check("rdw_new", v, 32'h0000_0055);

`ifdef DMEM_MMIO_TIMER_EN
        req(1'b0, MASK_W, Base + 11'(TMR_MTIMECMP), 32'd10, 1'b0, v);
        req(1'b0, MASK_W, Base + 11'(TMR_CTRL), 32'd1, 1'b0, v);
        req(1'b0, MASK_W, Base + 11'(TMR_MTIME), 32'd0, 1'b0, v);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            req(1'b1, MASK_W, Base + 11'(TMR_MTIME), 32'h0, 1'b0, v);
            if (v == 32'd9) check("irq_before_match", {31'h0, irq_o}, 32'h0);
            if (v == 32'd10) begin
                check("irq_after_match", {31'h0, irq_o}, 32'h1);
                seen = 1'b1;
            end
        end
        if (!seen) check("mtime_reached_10", 32'h0, 32'h1);
        req(1'b1, MASK_W, Base + 11'(TMR_CTRL), 32'h0, 1'b0, v);
        check("ctrl_pend_en", v, 32'h3);
        req(1'b0, MASK_W, Base + 11'(TMR_CTRL), 32'h3, 1'b0, v);
        check("irq_w1c", {31'h0, irq_o}, 32'h0);
        req(1'b1, MASK_W, Base + 11'(TMR_CTRL), 32'h0, 1'b0, v);
        check("ctrl_after_w1c", v, 32'h1);

        req(1'b0, MASK_W, Base + 11'(TMR_MTIME), 32'hFFFF_FFFF, 1'b0, v);
        req(1'b1, MASK_W, Base + 11'(TMR_MTIME), 32'h0, 1'b0, v);
        check("mtime_max", v, 32'hFFFF_FFFF);
        req(1'b1, MASK_W, Base + 11'(TMR_MTIME), 32'h0, 1'b0, v);
        check("mtime_wrap", v, 32'h0);

        req(1'b0, MASK_B, Base + 11'(TMR_MTIMECMP), 32'h55, 1'b0, v);
        check("mmio_byte_flag", {31'h0, misalign_o}, 32'h1);
        req(1'b1, MASK_W, Base + 11'(TMR_MTIMECMP), 32'h0, 1'b0, v);
        check("mmio_byte_dropped", v, 32'd10);
        req(1'b1, MASK_H, Base, 32'h0, 1'b0, v);
        check("mmio_half_zero", v, 32'h0);
        check("mmio_half_flag", {31'h0, misalign_o}, 32'h1);
        req(1'b1, MASK_W, Base + 11'(TMR_RSVD), 32'h0, 1'b0, v);
        check("mmio_rsvd", v, 32'h0);
`endif

        // Reset in the middle of a response cycle.
        req(1'b1, MASK_W, 11'h030, 32'h0, 1'b1, v);
        #2;
        reset_i = 1'b0;
        #1;
        check("midrst_rdata", rdata_o, 32'h0);
        check("midrst_misalign", {31'h0, misalign_o}, 32'h0);
        check("midrst_irq", {31'h0, irq_o}, 32'h0);
        @(negedge clk_i);
        reset_i = 1'b1;
`ifdef DMEM_MMIO_TIMER_EN
        req(1'b1, MASK_W, Base + 11'(TMR_MTIME), 32'h0, 1'b0, v);
        check("midrst_mtime", v, 32'h0);
`endif
        req(1'b1, MASK_W, 11'h030, 32'h0, 1'b1, v);
        check("post_rst_load", v, 32'hCAFE_F00D);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(2, 0))
                0:       m = MASK_B;
                1:       m = MASK_H;
                default: m = MASK_W;
            endcase
            req(1'(($urandom_range(2, 0) == 0) ? 1 : 0), m, 11'($urandom_range(SramTop - 1, 0)),
                $urandom, 1'b1, v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
